tt_vec_regfile_mp: RTL and testbench

- Next-generation vector register file: 32 x VLEN architectural registers.
- Parametrised number of read ports, each with a registered (1-cycle) read and write-first bypass.
- Byte-enabled writes and a hardware whole-file clear engine (FSM, 32 cycles).
- Sits between vector issue (operand read) and vector writeback; v0 mask and destination-old-value outputs feed masked/tail-undisturbed merge logic.

---
 rtl/tt_vec_regfile_mp_pkg.sv | 35 +++
 rtl/tt_vec_regfile_mp_if.sv | 33 +++
 rtl/tt_vec_regfile_mp_rdport.sv | 74 +++++++
 rtl/tt_vec_regfile_mp.sv | 108 ++++++++++
 tb/tb_tt_vec_regfile_mp.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/tt_vec_regfile_mp_pkg.sv
// Shared types, constants and byte helpers for the vector register file.
// Helpers work at VLEN_MAX width; callers zero-extend and size-cast back to VLEN.
package tt_vec_rf_pkg;

  localparam int unsigned NUM_VREG = 32;
  localparam int unsigned VREG_AW  = 5;
  localparam int unsigned VLEN_MAX = 2048;
  localparam int unsigned NB_MAX   = VLEN_MAX / 8;

  typedef logic [VLEN_MAX-1:0] vreg_max_t;
  typedef logic [NB_MAX-1:0]   vbe_max_t;

  typedef enum logic {IDLE, CLEAR} clr_state_e;

  function automatic vreg_max_t byte_merge(input vreg_max_t old_v, input vreg_max_t new_v,
                                           input vbe_max_t be);
    vreg_max_t r;
    r = old_v;
    for (int unsigned b = 0; b < NB_MAX; b++) begin
      if (be[b]) r[8*b +: 8] = new_v[8*b +: 8];
    end
    return r;
  endfunction

  // Even parity: the stored bit makes each byte-plus-parity have an even count of ones.
  function automatic vbe_max_t byte_parity(input vreg_max_t d);
    vbe_max_t p;
    p = '0;
    for (int unsigned b = 0; b < NB_MAX; b++) begin
      p[b] = ^d[8*b +: 8];
    end
    return p;
  endfunction

endpackage

// File: rtl/tt_vec_regfile_mp_if.sv
// Issue/writeback bus of the vector register file; the slave modport is the file side.
// Carries o_par_err in all builds (driven only when TT_VEC_RF_PARITY_EN is defined).
interface tt_vec_regfile_mp_if #(
  parameter int unsigned VLEN   = 128,
  parameter int unsigned NUM_RD = 3
);
  import tt_vec_rf_pkg::*;

  logic [NUM_RD-1:0]              i_rden;
  logic [NUM_RD-1:0][VREG_AW-1:0] i_rdaddr;
  logic [NUM_RD-1:0][VLEN-1:0]    o_rddata;
  logic                           i_wren;
  logic [VREG_AW-1:0]             i_wraddr;
  logic [VLEN-1:0]                i_wrdata;
  logic [VLEN/8-1:0]              i_wrbe;
  logic                           o_wr_rdy;
  logic [VLEN-1:0]                o_dstmask;
  logic [VLEN-1:0]                o_vm0;
  logic                           i_clr_req;
  logic                           o_clr_busy;
  logic [NUM_RD-1:0]              o_par_err;

  modport master (
    output i_rden, i_rdaddr, i_wren, i_wraddr, i_wrdata, i_wrbe, i_clr_req,
    input  o_rddata, o_wr_rdy, o_dstmask, o_vm0, o_clr_busy, o_par_err
  );

  modport slave (
    input  i_rden, i_rdaddr, i_wren, i_wraddr, i_wrdata, i_wrbe, i_clr_req,
    output o_rddata, o_wr_rdy, o_dstmask, o_vm0, o_clr_busy, o_par_err
  );

endinterface

// File: rtl/tt_vec_regfile_mp_rdport.sv
// One registered read port with write-first/clear bypass.
// TT_VEC_RF_PARITY_EN adds the stored-parity check on array reads.
module tt_vec_rf_rdport
  import tt_vec_rf_pkg::*;
#(
  parameter int unsigned VLEN = 128
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               rden_i,
  input  logic [VREG_AW-1:0] rdaddr_i,
  input  logic [VLEN-1:0]    mem_i [NUM_VREG],
`ifdef TT_VEC_RF_PARITY_EN
  input  logic [VLEN/8-1:0]  par_i [NUM_VREG],
`endif
  input  logic               wr_fire_i,
  input  logic [VREG_AW-1:0] wraddr_i,
  input  logic [VLEN-1:0]    wrdata_i,
  input  logic [VLEN/8-1:0]  wrbe_i,
  input  logic               clr_fire_i,
  input  logic [VREG_AW-1:0] clr_ptr_i,
  output logic [VLEN-1:0]    rddata_o,
  output logic               par_err_o
);

  logic [VLEN-1:0] arr_data;
  logic [VLEN-1:0] rddata_d, rddata_q;
  logic            hit_clr, hit_wr;

  assign arr_data = mem_i[rdaddr_i];
  assign hit_clr  = clr_fire_i && (clr_ptr_i == rdaddr_i);
  assign hit_wr   = wr_fire_i && (wraddr_i == rdaddr_i);

  always_comb begin
    rddata_d = arr_data;
    if (hit_clr) begin
      rddata_d = '0;
    end else if (hit_wr) begin
      rddata_d = VLEN'(byte_merge(vreg_max_t'(arr_data), vreg_max_t'(wrdata_i),
                                  vbe_max_t'(wrbe_i)));
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rddata_q <= '0;
    end else if (rden_i) begin
      rddata_q <= rddata_d;
    end
  end

  assign rddata_o = rddata_q;

`ifdef TT_VEC_RF_PARITY_EN
  logic par_err_d, par_err_q;

  // Bypassed data never came from storage, so there is nothing to check.
  assign par_err_d = !(hit_clr || hit_wr) &&
                     ((VLEN/8)'(byte_parity(vreg_max_t'(arr_data))) != par_i[rdaddr_i]);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      par_err_q <= 1'b0;
    end else if (rden_i) begin
      par_err_q <= par_err_d;
    end
  end

  assign par_err_o = par_err_q;
`else
  assign par_err_o = 1'b0;
`endif

endmodule

// File: rtl/tt_vec_regfile_mp.sv
// 32 x VLEN vector register file: byte-enabled write, NUM_RD registered read ports,
// 32-cycle clear engine. TT_VEC_RF_PARITY_EN enables per-byte stored parity.
module tt_vec_regfile_mp
  import tt_vec_rf_pkg::*;
#(
  parameter int unsigned VLEN   = 128,
  parameter int unsigned NUM_RD = 3
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  tt_vec_regfile_mp_if.slave    bus
);

  logic [VLEN-1:0]         mem_q [NUM_VREG];
  clr_state_e              state_q, state_d;
  logic [VREG_AW-1:0]      ptr_q, ptr_d;
  logic                    clr_fire, wr_fire;
  logic [VLEN-1:0]         wr_merged;
  logic [NUM_RD-1:0][VLEN-1:0] rddata;
  logic [NUM_RD-1:0]       par_err;

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    clr_fire = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.i_clr_req) begin
          state_d = CLEAR;
          ptr_d   = '0;
        end
      end
      CLEAR: begin
        clr_fire = 1'b1;
        ptr_d    = ptr_q + 5'd1;
        if (ptr_q == 5'(NUM_VREG - 1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  assign bus.o_clr_busy = (state_q == CLEAR);
  assign bus.o_wr_rdy   = (state_q == IDLE);
  assign wr_fire        = bus.i_wren && (state_q == IDLE);
  assign wr_merged      = VLEN'(byte_merge(vreg_max_t'(mem_q[bus.i_wraddr]),
                                           vreg_max_t'(bus.i_wrdata),
                                           vbe_max_t'(bus.i_wrbe)));

  // Clear and write never coincide: writes are only accepted in IDLE.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int unsigned i = 0; i < NUM_VREG; i++) mem_q[i] <= '0;
    end else begin
      if (clr_fire) mem_q[ptr_q] <= '0;
      if (wr_fire)  mem_q[bus.i_wraddr] <= wr_merged;
    end
  end

`ifdef TT_VEC_RF_PARITY_EN
  logic [VLEN/8-1:0] par_q [NUM_VREG];

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int unsigned i = 0; i < NUM_VREG; i++) par_q[i] <= '0;
    end else begin
      if (clr_fire) par_q[ptr_q] <= '0;
      if (wr_fire)  par_q[bus.i_wraddr] <= (VLEN/8)'(byte_parity(vreg_max_t'(wr_merged)));
    end
  end
`endif

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    tt_vec_rf_rdport #(.VLEN(VLEN)) u_rd (
      .clk_i      (i_clk),
      .rst_i      (i_reset),
      .rden_i     (bus.i_rden[p]),
      .rdaddr_i   (bus.i_rdaddr[p]),
      .mem_i      (mem_q),
`ifdef TT_VEC_RF_PARITY_EN
      .par_i      (par_q),
`endif
      .wr_fire_i  (wr_fire),
      .wraddr_i   (bus.i_wraddr),
      .wrdata_i   (bus.i_wrdata),
      .wrbe_i     (bus.i_wrbe),
      .clr_fire_i (clr_fire),
      .clr_ptr_i  (ptr_q),
      .rddata_o   (rddata[p]),
      .par_err_o  (par_err[p])
    );
  end

  assign bus.o_rddata  = rddata;
  assign bus.o_par_err = par_err;
  assign bus.o_dstmask = mem_q[bus.i_wraddr];
  assign bus.o_vm0     = mem_q[0];

endmodule

// File: tb/tb_tt_vec_regfile_mp.sv
// Scoreboard bench for tt_vec_regfile_mp: stimulus queues expected read data, a monitor
// checks each port one cycle after its read enable. Parity case needs TT_VEC_RF_PARITY_EN.
module tb_tt_vec_regfile_mp;

  localparam int unsigned VLEN   = 128;
  localparam int unsigned NUM_RD = 3;
  localparam int unsigned NB     = VLEN / 8;

  typedef logic [VLEN-1:0] vec_t;
  typedef logic [NB-1:0]   be_t;
  typedef struct {
    int    port;
    vec_t  data;
    logic  perr;
    string name;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tt_vec_regfile_mp_if #(.VLEN(VLEN), .NUM_RD(NUM_RD)) bus ();

  tt_vec_regfile_mp #(.VLEN(VLEN), .NUM_RD(NUM_RD)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  vec_t model [32];

  function automatic vec_t merge(input vec_t o, input vec_t n, input be_t be);
    vec_t r;
    r = o;
    for (int b = 0; b < int'(NB); b++) if (be[b]) r[8*b +: 8] = n[8*b +: 8];
    return r;
  endfunction

  task automatic check(input string name, input vec_t act, input vec_t exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.i_rden    = '0;
    bus.i_rdaddr  = '0;
    bus.i_wren    = 1'b0;
    bus.i_wraddr  = '0;
    bus.i_wrdata  = '0;
    bus.i_wrbe    = '0;
    bus.i_clr_req = 1'b0;
  endtask

  // One clock of stimulus; read ports in rm all read address ra and expect rexp.
  task automatic cyc(input bit we, input int wa, input vec_t wd, input be_t be,
                     input logic [NUM_RD-1:0] rm, input int ra, input vec_t rexp,
                     input logic [NUM_RD-1:0] perr, input bit clr, input string name);
    exp_t e;
    bus.i_wren    = we;
    bus.i_wraddr  = 5'(wa);
    bus.i_wrdata  = wd;
    bus.i_wrbe    = be;
    bus.i_clr_req = clr;
    bus.i_rden    = rm;
    for (int p = 0; p < int'(NUM_RD); p++) bus.i_rdaddr[p] = 5'(ra);
    for (int p = 0; p < int'(NUM_RD); p++) begin
      if (rm[p]) begin
        e.port = p; e.data = rexp; e.perr = perr[p]; e.name = name;
        sb.push_back(e);
      end
    end
    if (we && bus.o_wr_rdy) model[wa] = merge(model[wa], wd, be);
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic wr(input int wa, input vec_t wd, input be_t be);
    cyc(1'b1, wa, wd, be, '0, 0, '0, '0, 1'b0, "wr");
  endtask

  task automatic rd(input logic [NUM_RD-1:0] rm, input int ra, input vec_t exp, input string name);
    cyc(1'b0, 0, '0, '0, rm, ra, exp, '0, 1'b0, name);
  endtask

  task automatic fill_all();
    for (int i = 0; i < 32; i++) wr(i, {4{32'hC0DE0000 + 32'(i)}}, '1);
  endtask

  // Monitor: a port presents data the cycle after its enabled read edge.
  initial begin : monitor
    logic [NUM_RD-1:0] issued;
    exp_t e;
    forever begin
      @(posedge clk);
      issued = rst ? '0 : bus.i_rden;
      if (!rst && bus.i_wren && !bus.o_wr_rdy) begin
        n_fail++;
        $display("FAIL wr_while_busy: write issued with o_wr_rdy=0");
      end
      #1;
      for (int p = 0; p < int'(NUM_RD); p++) begin
        if (issued[p]) begin
          n_tests++;
          if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL sb_empty: port %0d got %h with no expectation", p, bus.o_rddata[p]);
          end else begin
            e = sb.pop_front();
            if (e.port != p || bus.o_rddata[p] !== e.data || bus.o_par_err[p] !== e.perr) begin
              n_fail++;
              $display("FAIL %s port %0d: got %h perr %b expected port %0d %h perr %b",
                       e.name, p, bus.o_rddata[p], bus.o_par_err[p], e.port, e.data, e.perr);
            end
          end
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    vec_t exp_v;
    logic [NUM_RD-1:0] rm;
    idle_inputs();
    for (int i = 0; i < 32; i++) model[i] = '0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    check("rst_clr_busy", vec_t'(bus.o_clr_busy), '0);
    check("rst_wr_rdy", vec_t'(bus.o_wr_rdy), vec_t'(1));
    check("rst_vm0", bus.o_vm0, '0);
    check("rst_par_err", vec_t'(bus.o_par_err), '0);
    for (int p = 0; p < int'(NUM_RD); p++) check("rst_rddata", bus.o_rddata[p], '0);
    for (int a = 0; a < 32; a++) rd('1, a, '0, "rd_after_rst");

    // Byte-enabled partial write.
    wr(5, {16{8'hA5}}, '1);
    wr(5, {16{8'h3C}}, 16'h000F);
    exp_v = {{12{8'hA5}}, {4{8'h3C}}};
    bus.i_wraddr = 5'd5;
    #1;
    check("dstmask_v5", bus.o_dstmask, exp_v);
    rd('1, 5, exp_v, "rd_v5_partial");

    // Write-first bypass: full and merged.
    cyc(1'b1, 7, '1, '1, '1, 7, '1, '0, 1'b0, "bypass_v7_full");
    exp_v = {{4{8'h11}}, {8{8'hA5}}, {4{8'h3C}}};
    cyc(1'b1, 5, {16{8'h11}}, 16'hF000, '1, 5, exp_v, '0, 1'b0, "bypass_v5_merge");
    wr(5, '1, '0);
    rd(3'b001, 5, exp_v, "be_zero_noop");
    rd(3'b100, 7, '1, "rd_v7_after");

    wr(0, {4{32'h0BADF00D}}, '1);
    check("vm0_written", bus.o_vm0, {4{32'h0BADF00D}});

    // Clear engine with a simultaneous write that must land and then be cleared.
    fill_all();
    cyc(1'b1, 9, {16{8'h99}}, '1, '0, 0, '0, '0, 1'b1, "clr_start");
    for (int c = 0; c < 32; c++) begin
      check("clr_busy", vec_t'(bus.o_clr_busy), vec_t'(1));
      check("clr_wr_rdy", vec_t'(bus.o_wr_rdy), '0);
      if (c == 0) check("clr_vm0_old", bus.o_vm0, {4{32'hC0DE0000}});
      else        check("clr_vm0_zero", bus.o_vm0, '0);
      rm    = (c == 10 || c == 31) ? '1 : '0;
      exp_v = (c == 10) ? model[31] : '0;
      cyc(1'b0, 0, '0, '0, rm, 31, exp_v, '0, 1'b0, (c == 10) ? "clr_v31_old" : "clr_v31_bypass");
    end
    check("clr_done_busy", vec_t'(bus.o_clr_busy), '0);
    check("clr_done_wr_rdy", vec_t'(bus.o_wr_rdy), vec_t'(1));
    for (int i = 0; i < 32; i++) model[i] = '0;
    rd('1, 9, '0, "clr_v9_zero");
    rd('1, 0, '0, "clr_v0_zero");
    rd('1, 20, '0, "clr_v20_zero");

    // Reset in the middle of a clear.
    fill_all();
    cyc(1'b0, 0, '0, '0, '0, 0, '0, '0, 1'b1, "clr2_start");
    repeat (15) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 32; i++) model[i] = '0;
    check("rstclr_busy", vec_t'(bus.o_clr_busy), '0);
    check("rstclr_wr_rdy", vec_t'(bus.o_wr_rdy), vec_t'(1));
    for (int p = 0; p < int'(NUM_RD); p++) check("rstclr_rddata", bus.o_rddata[p], '0);
    for (int a = 0; a < 32; a++) rd('1, a, '0, "rstclr_rd_zero");

`ifdef TT_VEC_RF_PARITY_EN
    wr(3, {16{8'h5A}}, '1);
    wr(4, {16{8'h66}}, '1);
    dut.mem_q[3][0] = ~dut.mem_q[3][0];
    cyc(1'b0, 0, '0, '0, 3'b010, 3, {{15{8'h5A}}, 8'h5B}, 3'b010, 1'b0, "par_err_v3");
    cyc(1'b0, 0, '0, '0, 3'b010, 4, {16{8'h66}}, 3'b000, 1'b0, "par_clean_v4");
`endif

    repeat (3) @(negedge clk);
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: %0d expectations left, required 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
